// File: rtl/led_pkg.sv
// Shared types and constants for the LED bank sequencer.
// Mode encoding, pattern limits and small pattern helpers.
package led_pkg;

    localparam int LED_W    = 8;
    localparam int SCAN_MAX = 7;
    localparam int FILL_MAX = 8;

    typedef enum logic [1:0] {
        MODE_COUNT,
        MODE_SCAN,
        MODE_BLINK,
        MODE_FILL
    } mode_e;

    function automatic logic [LED_W-1:0] fill_mask(input logic [3:0] lvl);
        logic [LED_W:0] t;
        t = ((LED_W+1)'(1) << lvl) - (LED_W+1)'(1);
        return t[LED_W-1:0];
    endfunction

    function automatic logic [LED_W-1:0] init_leds(input mode_e m);
        logic [LED_W-1:0] v;
        v = '0;
        case (m)
            MODE_SCAN:  v = LED_W'(1);
            MODE_BLINK: v = '1;
            default:    v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce,
// and a single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 100_000
) (
    input  logic clk,
    input  logic rst_s,
    input  logic din,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_press;
    logic          w_synced;
    logic          w_done;

    assign w_synced = r_sync[1];
    // Last of DEBOUNCE_CYC consecutive cycles with a differing level
    assign w_done = (w_synced != r_stable)
                 && (r_cnt == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], din};
            r_press <= w_done & w_synced;
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/led_sequencer.sv
// LED bank controller: four display modes stepped by a prescaler,
// advanced by a debounced button and frozen by a pause switch.
module led_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV     = 1_000_000,
    parameter int DEBOUNCE_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       pause,
    output logic [7:0] leds,
    output logic [1:0] mode
);

    localparam int PW = $clog2(TICK_DIV);

    logic             r_rst_meta;
    logic             r_rst_s;
    logic [1:0]       r_pause_sync;
    logic [PW-1:0]    r_presc;
    mode_e            r_mode;
    logic [LED_W-1:0] r_cnt8;
    logic [2:0]       r_pos;
    logic             r_dir;
    logic             r_blink;
    logic [3:0]       r_level;
    logic [LED_W-1:0] r_leds;

    logic             w_pause_s;
    logic             w_press;
    logic             w_tick;
    logic [PW-1:0]    w_presc_nxt;
    mode_e            w_mode_nxt;
    logic [LED_W-1:0] w_cnt_nxt;
    logic [2:0]       w_pos_nxt;
    logic             w_dir_nxt;
    logic             w_blink_nxt;
    logic [3:0]       w_level_nxt;
    logic [LED_W-1:0] w_leds_nxt;

    // Asserts with rst, releases two edges after rst falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_meta <= 1'b1;
            r_rst_s    <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_s    <= r_rst_meta;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk  (clk),
        .rst_s(r_rst_s),
        .din  (btn),
        .press(w_press)
    );

    assign w_pause_s = r_pause_sync[1];
    assign w_tick    = !w_pause_s && (r_presc == PW'(TICK_DIV - 1));

    always_comb begin
        w_presc_nxt = r_presc;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt8;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_blink_nxt = r_blink;
        w_level_nxt = r_level;
        w_leds_nxt  = r_leds;
        if (!w_pause_s) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        end
        // A press discards any coincident tick
        if (w_press) begin
            w_presc_nxt = '0;
            w_mode_nxt  = mode_e'(r_mode + 2'd1);
            w_cnt_nxt   = '0;
            w_pos_nxt   = '0;
            w_dir_nxt   = 1'b1;
            w_blink_nxt = 1'b1;
            w_level_nxt = '0;
            w_leds_nxt  = init_leds(w_mode_nxt);
        end else if (w_tick) begin
            unique case (r_mode)
                MODE_COUNT: begin
                    w_cnt_nxt  = r_cnt8 + 1'b1;
                    w_leds_nxt = w_cnt_nxt;
                end
                MODE_SCAN: begin
                    if (r_dir) begin
                        if (r_pos == 3'(SCAN_MAX)) begin
                            w_pos_nxt = r_pos - 1'b1;
                            w_dir_nxt = 1'b0;
                        end else begin
                            w_pos_nxt = r_pos + 1'b1;
                        end
                    end else begin
                        if (r_pos == 3'd0) begin
                            w_pos_nxt = 3'd1;
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos - 1'b1;
                        end
                    end
                    w_leds_nxt = LED_W'(1) << w_pos_nxt;
                end
                MODE_BLINK: begin
                    w_blink_nxt = ~r_blink;
                    w_leds_nxt  = {LED_W{w_blink_nxt}};
                end
                MODE_FILL: begin
                    if (r_level == 4'(FILL_MAX)) begin
                        w_level_nxt = '0;
                    end else begin
                        w_level_nxt = r_level + 1'b1;
                    end
                    w_leds_nxt = fill_mask(w_level_nxt);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge r_rst_s) begin
        if (r_rst_s) begin
            r_pause_sync <= '0;
            r_presc      <= '0;
            r_mode       <= MODE_COUNT;
            r_cnt8       <= '0;
            r_pos        <= '0;
            r_dir        <= 1'b1;
            r_blink      <= 1'b1;
            r_level      <= '0;
            r_leds       <= '0;
        end else begin
            r_pause_sync <= {r_pause_sync[0], pause};
            r_presc      <= w_presc_nxt;
            r_mode       <= w_mode_nxt;
            r_cnt8       <= w_cnt_nxt;
            r_pos        <= w_pos_nxt;
            r_dir        <= w_dir_nxt;
            r_blink      <= w_blink_nxt;
            r_level      <= w_level_nxt;
            r_leds       <= w_leds_nxt;
        end
    end

    assign leds = r_leds;
    assign mode = r_mode;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4, DEBOUNCE_CYC=3.
// Each task drives one scenario and checks hand-computed values.
module tb_led_sequencer;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       pause;
    logic [7:0] leds;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;

    led_sequencer #(
        .TICK_DIV    (4),
        .DEBOUNCE_CYC(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .pause(pause),
        .leds (leds),
        .mode (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press is consumed on the 6th edge after btn rises
    task automatic press_btn();
        btn = 1'b1;
        step(6);
        btn = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; pause = 1'b0;
        step(3);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL rst_leds: got %h want %h", leds, 8'h00); end
        n_checks++; if (mode !== 2'd0) begin n_errors++; $display("FAIL rst_mode: got %0d want %0d", mode, 0); end
        rst = 1'b0;
        step(5);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL first_pre: got %h want %h", leds, 8'h00); end
        step(1);
        n_checks++; if (leds !== 8'h01) begin n_errors++; $display("FAIL first_step: got %h want %h", leds, 8'h01); end
        step(4);
        n_checks++; if (leds !== 8'h02) begin n_errors++; $display("FAIL count2: got %h want %h", leds, 8'h02); end
        step(4);
        n_checks++; if (leds !== 8'h03) begin n_errors++; $display("FAIL count3: got %h want %h", leds, 8'h03); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL async_leds: got %h want %h", leds, 8'h00); end
        n_checks++; if (mode !== 2'd0) begin n_errors++; $display("FAIL async_mode: got %0d want %0d", mode, 0); end
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_count_wrap();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1022);
        n_checks++; if (leds !== 8'hFF) begin n_errors++; $display("FAIL count_ff: got %h want %h", leds, 8'hFF); end
        step(3);
        n_checks++; if (leds !== 8'hFF) begin n_errors++; $display("FAIL count_hold: got %h want %h", leds, 8'hFF); end
        step(1);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL count_wrap: got %h want %h", leds, 8'h00); end
    endtask

    task automatic test_debounce();
        restart();
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1; step(1); btn = 1'b0; step(6);
            btn = 1'b1; step(2); btn = 1'b0; step(6);
        end
        n_checks++; if (mode !== 2'd0) begin n_errors++; $display("FAIL bounce_mode: got %0d want %0d", mode, 0); end
        btn = 1'b1;
        step(5);
        n_checks++; if (mode !== 2'd0) begin n_errors++; $display("FAIL hold_early: got %0d want %0d", mode, 0); end
        step(1);
        n_checks++; if (mode !== 2'd1) begin n_errors++; $display("FAIL hold_mode: got %0d want %0d", mode, 1); end
        n_checks++; if (leds !== 8'h01) begin n_errors++; $display("FAIL hold_leds: got %h want %h", leds, 8'h01); end
        step(4);
        btn = 1'b0;
        step(10);
        n_checks++; if (mode !== 2'd1) begin n_errors++; $display("FAIL one_press: got %0d want %0d", mode, 1); end
        press_btn();
        n_checks++; if (mode !== 2'd2) begin n_errors++; $display("FAIL repress: got %0d want %0d", mode, 2); end
        step(6);
    endtask

    task automatic test_scan();
        logic [7:0] exp_scan [16];
        exp_scan = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        restart();
        press_btn();
        n_checks++; if (leds !== 8'h01) begin n_errors++; $display("FAIL scan_init: got %h want %h", leds, 8'h01); end
        for (int k = 0; k < 16; k++) begin
            step(4);
            n_checks++; if (leds !== exp_scan[k]) begin n_errors++; $display("FAIL scan_%0d: got %h want %h", k, leds, exp_scan[k]); end
        end
    endtask

    task automatic test_blink_pause();
        restart();
        press_btn();
        step(5);
        press_btn();
        n_checks++; if (mode !== 2'd2) begin n_errors++; $display("FAIL blink_mode: got %0d want %0d", mode, 2); end
        n_checks++; if (leds !== 8'hFF) begin n_errors++; $display("FAIL blink_init: got %h want %h", leds, 8'hFF); end
        step(4);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL blink_tog: got %h want %h", leds, 8'h00); end
        step(1);
        pause = 1'b1;
        step(12);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL pause_a: got %h want %h", leds, 8'h00); end
        step(8);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL pause_b: got %h want %h", leds, 8'h00); end
        pause = 1'b0;
        step(2);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL resume_pre: got %h want %h", leds, 8'h00); end
        step(1);
        n_checks++; if (leds !== 8'hFF) begin n_errors++; $display("FAIL resume: got %h want %h", leds, 8'hFF); end
        pause = 1'b1;
        step(4);
        press_btn();
        n_checks++; if (mode !== 2'd3) begin n_errors++; $display("FAIL pause_press: got %0d want %0d", mode, 3); end
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL pause_fill: got %h want %h", leds, 8'h00); end
        step(8);
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL pause_frz: got %h want %h", leds, 8'h00); end
        pause = 1'b0;
        step(2);
    endtask

    task automatic test_fill();
        logic [7:0] exp_fill [9];
        exp_fill = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                     8'h3F, 8'h7F, 8'hFF, 8'h00};
        restart();
        press_btn();
        step(5);
        press_btn();
        step(5);
        press_btn();
        n_checks++; if (mode !== 2'd3) begin n_errors++; $display("FAIL fill_mode: got %0d want %0d", mode, 3); end
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL fill_init: got %h want %h", leds, 8'h00); end
        for (int k = 0; k < 9; k++) begin
            step(4);
            n_checks++; if (leds !== exp_fill[k]) begin n_errors++; $display("FAIL fill_%0d: got %h want %h", k, leds, exp_fill[k]); end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(20);
        btn = 1'b1;
        step(2);
        n_checks++; if (leds !== 8'h05) begin n_errors++; $display("FAIL coll_pre: got %h want %h", leds, 8'h05); end
        step(4);
        n_checks++; if (mode !== 2'd1) begin n_errors++; $display("FAIL coll_mode: got %0d want %0d", mode, 1); end
        n_checks++; if (leds !== 8'h01) begin n_errors++; $display("FAIL coll_leds: got %h want %h", leds, 8'h01); end
        btn = 1'b0;
        step(3);
        n_checks++; if (leds !== 8'h01) begin n_errors++; $display("FAIL coll_hold: got %h want %h", leds, 8'h01); end
        step(1);
        n_checks++; if (leds !== 8'h02) begin n_errors++; $display("FAIL coll_next: got %h want %h", leds, 8'h02); end
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        pause = 1'b0;
        test_reset();
        test_count_wrap();
        test_debounce();
        test_scan();
        test_blink_pause();
        test_fill();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
